// File: rtl/wtch_ascii_sender.sv
// Streams a snapshot of the packed watch time as the ASCII frame "HH:MM:SS.CC"
// plus line terminator, one byte per valid/ready transfer.
module wtch_ascii_sender #(
   parameter bit USE_CRLF = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [23:0] wtch_data,
   input  logic        send_req,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready,
   output logic        busy,
   output logic        req_lost
);

   typedef enum logic [1:0] {IDLE, CONV, SEND} state_t;

   localparam logic [3:0] LAST = USE_CRLF ? 4'd12 : 4'd11;

   state_t      state, state_nxt;
   logic [23:0] snap_p0;
   logic [31:0] dig_p1;
   logic [3:0]  idx;
   logic        xfer;
   logic        req_lost_r;

   // Two BCD digits {tens, ones}; anything above 99 saturates to 99.
   function automatic logic [7:0] to_bcd(input logic [6:0] v);
      logic [3:0] tens;
      logic [3:0] ones;
      tens = 4'd0;
      ones = 4'd9;
      if (v > 7'd99) begin
         tens = 4'd9;
      end else begin
         for (int k = 1; k <= 9; k++)
            if (v >= 7'(10 * k)) tens = 4'(k);
         ones = 4'(v - ({3'd0, tens} * 7'd10));
      end
      return {tens, ones};
   endfunction

   function automatic logic [7:0] asc(input logic [3:0] n);
      return 8'h30 + {4'h0, n};
   endfunction

   // Frame layout: H1 H0 : M1 M0 : S1 S0 . C1 C0 [CR] LF
   function automatic logic [7:0] frame_byte(input logic [3:0] i, input logic [31:0] d);
      logic [7:0] b;
      case (i)
         4'd0:    b = asc(d[31:28]);
         4'd1:    b = asc(d[27:24]);
         4'd2:    b = 8'h3A;
         4'd3:    b = asc(d[23:20]);
         4'd4:    b = asc(d[19:16]);
         4'd5:    b = 8'h3A;
         4'd6:    b = asc(d[15:12]);
         4'd7:    b = asc(d[11:8]);
         4'd8:    b = 8'h2E;
         4'd9:    b = asc(d[7:4]);
         4'd10:   b = asc(d[3:0]);
         4'd11:   b = USE_CRLF ? 8'h0D : 8'h0A;
         4'd12:   b = 8'h0A;
         default: b = 8'h00;
      endcase
      return b;
   endfunction

   assign tx_valid = (state == SEND);
   assign busy     = (state != IDLE);
   assign xfer     = tx_valid & tx_ready;
   assign tx_data  = tx_valid ? frame_byte(idx, dig_p1) : 8'h00;
   assign req_lost = req_lost_r;

   always_ff @(posedge clk) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (send_req) state_nxt = CONV;
         CONV:    state_nxt = SEND;
         SEND:    if (xfer && (idx == LAST)) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         snap_p0    <= 24'd0;
         dig_p1     <= 32'd0;
         idx        <= 4'd0;
         req_lost_r <= 1'b0;
      end else begin
         req_lost_r <= send_req && (state != IDLE);
         // p0: snapshot on accepted request
         if ((state == IDLE) && send_req)
            snap_p0 <= wtch_data;
         // p1: field-to-digit conversion
         if (state == CONV) begin
            dig_p1 <= {to_bcd({2'b00, snap_p0[23:19]}),
                       to_bcd({1'b0,  snap_p0[18:13]}),
                       to_bcd({1'b0,  snap_p0[12:7]}),
                       to_bcd(snap_p0[6:0])};
            idx    <= 4'd0;
         end
         if (xfer)
            idx <= (idx == LAST) ? 4'd0 : idx + 4'd1;
      end
   end

endmodule

// File: tb/tb_wtch_ascii_sender.sv
// Directed bench for wtch_ascii_sender: CRLF and LF-only builds driven in parallel.
module tb_wtch_ascii_sender;

   logic        clk = 1'b0;
   logic        rst;
   logic [23:0] wtch_data;
   logic        send_req;
   logic        tx_ready;
   logic [7:0]  tx_data, tx_data_lf;
   logic        tx_valid, tx_valid_lf;
   logic        busy, busy_lf;
   logic        req_lost, req_lost_lf;

   logic [7:0]  q1[$];
   logic [7:0]  q2[$];
   logic [23:0] chg_val;
   int          n_tests = 0;
   int          n_fail  = 0;
   int          nv, first, nlost;

   always #5 clk = ~clk;

   wtch_ascii_sender #(.USE_CRLF(1'b1)) u_dut (
      .clk(clk), .rst(rst), .wtch_data(wtch_data), .send_req(send_req),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .busy(busy), .req_lost(req_lost)
   );

   wtch_ascii_sender #(.USE_CRLF(1'b0)) u_dut_lf (
      .clk(clk), .rst(rst), .wtch_data(wtch_data), .send_req(send_req),
      .tx_data(tx_data_lf), .tx_valid(tx_valid_lf), .tx_ready(tx_ready),
      .busy(busy_lf), .req_lost(req_lost_lf)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [23:0] pack(input logic [4:0] h, input logic [5:0] m,
                                        input logic [5:0] s, input logic [6:0] c);
      return {h, m, s, c};
   endfunction

   task automatic check_frame(input string tag, input string exp, input bit lf);
      int n;
      n = lf ? q2.size() : q1.size();
      check($sformatf("%s_len", tag), n, exp.len());
      for (int i = 0; i < exp.len() && i < n; i++)
         check($sformatf("%s[%0d]", tag, i), lf ? q2[i] : q1[i], {24'd0, exp[i]});
   endtask

   task automatic begin_frame();
      q1.delete();
      q2.delete();
   endtask

   task automatic start_frame();
      @(posedge clk); #1 send_req = 1'b1;
      @(posedge clk); #1 send_req = 1'b0;
   endtask

   // Observes one frame from cycle 1 until the first IDLE cycle.
   task automatic run(input bit rnd, input bit chg, input bit lost, input bit rearm,
                      output int o_nv, output int o_first, output int o_nlost);
      bit         sent = 1'b0;
      bit         prev_stall = 1'b0;
      logic [7:0] prev_data = 8'h00;
      o_nv = 0; o_first = -1; o_nlost = 0;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         if (i == 0) check("busy_c1", busy, 1);
         if (prev_stall) begin
            check("hold_vld", tx_valid, 1);
            check("hold_data", tx_data, prev_data);
         end
         prev_stall = tx_valid && !tx_ready;
         prev_data  = tx_data;
         if (tx_valid) begin
            o_nv++;
            if (o_first < 0) o_first = i;
         end
         if (req_lost) o_nlost++;
         if (tx_valid && tx_ready) q1.push_back(tx_data);
         if (tx_valid_lf && tx_ready) q2.push_back(tx_data_lf);
         if (chg && q1.size() == 2) wtch_data = chg_val;
         if (!busy) return;
         @(posedge clk); #1;
         if (rnd) tx_ready = ($urandom_range(9) < 3);
         if (lost) begin
            send_req = (q1.size() == 5) && !sent;
            if (send_req) sent = 1'b1;
         end
         if (rearm && q1.size() == 13) send_req = 1'b1;
      end
      check("timeout", 0, 1);
   endtask

   initial begin
      rst = 1'b0; send_req = 1'b0; tx_ready = 1'b1; wtch_data = 24'd0; chg_val = 24'd0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_valid", tx_valid, 0);
      check("rst_data", tx_data, 8'h00);
      check("rst_busy", busy, 0);
      check("rst_lost", req_lost, 0);
      @(posedge clk); #1 rst = 1'b1;

      // T1: nominal frame, full throughput
      wtch_data = pack(5'd12, 6'd34, 6'd56, 7'd78);
      begin_frame(); start_frame();
      run(0, 0, 0, 0, nv, first, nlost);
      check("t1_first", first, 1);
      check("t1_nvalid", nv, 13);
      check_frame("t1", "12:34:56.78\r\n", 0);
      check_frame("t1_lf", "12:34:56.78\n", 1);
      check("t1_busy_end", busy, 0);

      // T2: random back-pressure
      begin_frame(); start_frame();
      run(1, 0, 0, 0, nv, first, nlost);
      tx_ready = 1'b1;
      check_frame("t2", "12:34:56.78\r\n", 0);
      check_frame("t2_lf", "12:34:56.78\n", 1);

      // T3: zero time, then msec saturation
      wtch_data = 24'd0;
      begin_frame(); start_frame();
      run(0, 0, 0, 0, nv, first, nlost);
      check_frame("t3a", "00:00:00.00\r\n", 0);
      wtch_data = pack(5'd0, 6'd0, 6'd0, 7'd120);
      begin_frame(); start_frame();
      run(0, 0, 0, 0, nv, first, nlost);
      check_frame("t3b", "00:00:00.99\r\n", 0);
      check_frame("t3b_lf", "00:00:00.99\n", 1);

      // T4: input change mid-frame does not reach the frame in flight
      wtch_data = pack(5'd12, 6'd34, 6'd56, 7'd78);
      chg_val   = pack(5'd1, 6'd2, 6'd3, 7'd4);
      begin_frame(); start_frame();
      run(0, 1, 0, 0, nv, first, nlost);
      check_frame("t4a", "12:34:56.78\r\n", 0);
      begin_frame(); start_frame();
      run(0, 0, 0, 0, nv, first, nlost);
      check_frame("t4b", "01:02:03.04\r\n", 0);

      // T5: request while busy is dropped; request in first IDLE cycle is taken
      wtch_data = pack(5'd23, 6'd59, 6'd58, 7'd9);
      begin_frame(); start_frame();
      run(0, 0, 1, 0, nv, first, nlost);
      check("t5_lost", nlost, 1);
      check_frame("t5a", "23:59:58.09\r\n", 0);
      repeat (3) @(negedge clk);
      check("t5_single", busy, 0);
      begin_frame(); start_frame();
      run(0, 0, 0, 1, nv, first, nlost);
      check("t5_nolost", nlost, 0);
      check_frame("t5b", "23:59:58.09\r\n", 0);
      @(posedge clk); #1 send_req = 1'b0;
      begin_frame();
      run(0, 0, 0, 0, nv, first, nlost);
      check("t5c_first", first, 1);
      check_frame("t5c", "23:59:58.09\r\n", 0);

      // T6: reset mid-frame
      wtch_data = pack(5'd1, 6'd2, 6'd3, 7'd4);
      begin_frame(); start_frame();
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (tx_valid && tx_ready) q1.push_back(tx_data);
         if (q1.size() == 5) break;
      end
      check("t6_bytes", q1.size(), 5);
      @(posedge clk); #1 rst = 1'b0;
      @(posedge clk); #1 rst = 1'b1;
      @(negedge clk);
      check("t6_valid", tx_valid, 0);
      check("t6_busy", busy, 0);
      check("t6_data", tx_data, 8'h00);
      begin_frame(); start_frame();
      run(0, 0, 0, 0, nv, first, nlost);
      check_frame("t6", "01:02:03.04\r\n", 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
